// File: rtl/usb_data_buffer.sv
// Shared byte FIFO between AHB registers and USB RX/TX engines; RX store beats AHB store, TX fetch beats AHB read.
// Latency: a write is visible at the head one edge later; the head byte is combinational from storage.
// Backpressure: no stall. Writes to a full FIFO and reads from an empty one are dropped; sticky flags when USB_DATA_BUFFER_ERR_FLAGS_EN.
module usb_data_buffer #(
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       store_tx_data,
    input  logic [7:0]                 tx_data,
    input  logic                       get_rx_data,
    output logic [7:0]                 rx_data,
    input  logic                       store_rx_packet_data,
    input  logic [7:0]                 rx_packet_data,
    input  logic                       get_tx_packet_data,
    output logic [7:0]                 tx_packet_data,
    input  logic                       clear,
    output logic [$clog2(DEPTH):0]     buffer_occupancy,
    output logic                       overflow_err,
    output logic                       underflow_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [AW:0] occ;
    logic        empty;
    logic        full;
    logic        wr_req;
    logic        rd_req;
    logic        wr_ok;
    logic        rd_ok;
    logic [7:0]  wr_byte;
    logic [7:0]  head;

    assign occ     = wptr - rptr;
    assign empty   = (occ == '0);
    assign full    = (occ == FULL_CNT);
    assign wr_req  = store_rx_packet_data | store_tx_data;
    assign rd_req  = get_tx_packet_data | get_rx_data;
    assign wr_byte = store_rx_packet_data ? rx_packet_data : tx_data;
    assign rd_ok   = rd_req & ~empty;
    // A concurrent pop frees the slot, so a full FIFO still takes the byte.
    assign wr_ok   = wr_req & (~full | rd_ok);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
        end
    end

    // Storage is deliberately left out of reset and clear.
    always_ff @(posedge clk) begin
        if (wr_ok && !clear) mem[wptr[AW-1:0]] <= wr_byte;
    end

    assign head             = empty ? 8'h00 : mem[rptr[AW-1:0]];
    assign rx_data          = head;
    assign tx_packet_data   = head;
    assign buffer_occupancy = occ;

`ifdef USB_DATA_BUFFER_ERR_FLAGS_EN
    logic ovf_evt;
    logic udf_evt;
    // Both strobes high always loses the AHB byte, even when the RX byte is taken.
    assign ovf_evt = (wr_req & ~wr_ok) | (store_rx_packet_data & store_tx_data);
    assign udf_evt = rd_req & empty;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else if (clear) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (ovf_evt) overflow_err  <= 1'b1;
            if (udf_evt) underflow_err <= 1'b1;
        end
    end
`else
    assign overflow_err  = 1'b0;
    assign underflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_usb_data_buffer.sv
// Directed bench for usb_data_buffer; flag expectations follow USB_DATA_BUFFER_ERR_FLAGS_EN.
module tb_usb_data_buffer;
    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       store_tx_data = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       get_rx_data = 1'b0;
    logic [7:0] rx_data;
    logic       store_rx_packet_data = 1'b0;
    logic [7:0] rx_packet_data = 8'h00;
    logic       get_tx_packet_data = 1'b0;
    logic [7:0] tx_packet_data;
    logic       clear = 1'b0;
    logic [6:0] buffer_occupancy;
    logic       overflow_err;
    logic       underflow_err;

`ifdef USB_DATA_BUFFER_ERR_FLAGS_EN
    localparam logic EF = 1'b1;
`else
    localparam logic EF = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    usb_data_buffer #(.DEPTH(64)) dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .store_tx_data        (store_tx_data),
        .tx_data              (tx_data),
        .get_rx_data          (get_rx_data),
        .rx_data              (rx_data),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .get_tx_packet_data   (get_tx_packet_data),
        .tx_packet_data       (tx_packet_data),
        .clear                (clear),
        .buffer_occupancy     (buffer_occupancy),
        .overflow_err         (overflow_err),
        .underflow_err        (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // One clock with the given strobes; returns #1 after the edge with strobes idle.
    task automatic cyc(input logic srx, input logic [7:0] rxd, input logic stx, input logic [7:0] txd,
                       input logic gtx, input logic grx, input logic clr);
        store_rx_packet_data = srx;
        rx_packet_data       = rxd;
        store_tx_data        = stx;
        tx_data              = txd;
        get_tx_packet_data   = gtx;
        get_rx_data          = grx;
        clear                = clr;
        @(posedge clk);
        #1;
        store_rx_packet_data = 1'b0;
        store_tx_data        = 1'b0;
        get_tx_packet_data   = 1'b0;
        get_rx_data          = 1'b0;
        clear                = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        check_vec({tag, "_occ"}, {1'b0, buffer_occupancy}, 8'd0);
        check_vec({tag, "_head"}, rx_data, 8'h00);
        check_vec({tag, "_ovf"}, {7'b0, overflow_err}, 8'd0);
        check_vec({tag, "_udf"}, {7'b0, underflow_err}, 8'd0);
    endtask

    initial begin
        #2;
        chk_idle("reset");
        check_vec("reset_txpkt", tx_packet_data, 8'h00);
        #20 n_rst = 1'b1;
        @(posedge clk); #1;

        // AHB writes, USB TX pops in order
        cyc(0, 8'h00, 1, 8'h11, 0, 0, 0);
        cyc(0, 8'h00, 1, 8'h22, 0, 0, 0);
        cyc(0, 8'h00, 1, 8'h33, 0, 0, 0);
        cyc(0, 8'h00, 1, 8'h44, 0, 0, 0);
        check_vec("ahb4_occ", {1'b0, buffer_occupancy}, 8'd4);
        check_vec("pop0", tx_packet_data, 8'h11); cyc(0, 8'h00, 0, 8'h00, 1, 0, 0);
        check_vec("pop1", tx_packet_data, 8'h22); cyc(0, 8'h00, 0, 8'h00, 1, 0, 0);
        check_vec("pop2", tx_packet_data, 8'h33); cyc(0, 8'h00, 0, 8'h00, 1, 0, 0);
        check_vec("pop3", tx_packet_data, 8'h44); cyc(0, 8'h00, 0, 8'h00, 1, 0, 0);
        chk_idle("drained");

        // Fill, overflow, then write+read on full
        for (int i = 0; i < 64; i++) cyc(1, i[7:0], 0, 8'h00, 0, 0, 0);
        check_vec("fill_occ", {1'b0, buffer_occupancy}, 8'd64);
        cyc(1, 8'hAA, 0, 8'h00, 0, 0, 0);
        check_vec("ovf_occ", {1'b0, buffer_occupancy}, 8'd64);
        check_vec("ovf_flag", {7'b0, overflow_err}, {7'b0, EF});
        check_vec("full_head", rx_data, 8'h00);
        cyc(0, 8'h00, 1, 8'hBB, 0, 1, 0);
        check_vec("wr_rd_full_occ", {1'b0, buffer_occupancy}, 8'd64);
        for (int i = 1; i < 64; i++) begin
            check_vec("full_pop", rx_data, i[7:0]);
            cyc(0, 8'h00, 0, 8'h00, 0, 1, 0);
        end
        check_vec("bb_last", rx_data, 8'hBB);
        cyc(0, 8'h00, 0, 8'h00, 0, 1, 0);
        check_vec("after_bb_occ", {1'b0, buffer_occupancy}, 8'd0);
        cyc(0, 8'h00, 0, 8'h00, 0, 0, 1);
        chk_idle("clr1");

        // Read on empty is not satisfied by a concurrent write
        cyc(0, 8'h00, 1, 8'h5A, 0, 1, 0);
        check_vec("udf_occ", {1'b0, buffer_occupancy}, 8'd1);
        check_vec("udf_head", rx_data, 8'h5A);
        check_vec("udf_flag", {7'b0, underflow_err}, {7'b0, EF});
        cyc(0, 8'h00, 0, 8'h00, 0, 0, 1);
        chk_idle("clr2");

        // RX store wins over AHB store
        cyc(1, 8'h01, 1, 8'h02, 0, 0, 0);
        check_vec("prio_occ", {1'b0, buffer_occupancy}, 8'd1);
        check_vec("prio_head", tx_packet_data, 8'h01);
        check_vec("prio_ovf", {7'b0, overflow_err}, {7'b0, EF});
        cyc(0, 8'h00, 0, 8'h00, 1, 1, 0);
        check_vec("prio_pop_occ", {1'b0, buffer_occupancy}, 8'd0);
        cyc(0, 8'h00, 0, 8'h00, 0, 0, 1);
        chk_idle("clr3");

        // 70 streaming writes/pops across the pointer wrap
        cyc(0, 8'h00, 1, 8'h80, 0, 0, 0);
        for (int k = 1; k < 70; k++) begin
            check_vec("wrap_pop", tx_packet_data, 8'h80 + 8'(k - 1));
            cyc(0, 8'h00, 1, 8'h80 + k[7:0], 1, 0, 0);
            if (k == 69) check_vec("wrap_occ", {1'b0, buffer_occupancy}, 8'd1);
        end
        check_vec("wrap_last", tx_packet_data, 8'hC5);
        cyc(0, 8'h00, 0, 8'h00, 1, 0, 0);
        cyc(0, 8'h00, 0, 8'h00, 1, 0, 0);
        check_vec("wrap_udf", {7'b0, underflow_err}, {7'b0, EF});
        cyc(0, 8'h00, 1, 8'hEE, 0, 0, 1);
        chk_idle("clr_wr");

        // Asynchronous reset mid-burst
        cyc(1, 8'h10, 0, 8'h00, 0, 0, 0);
        cyc(1, 8'h20, 0, 8'h00, 0, 0, 0);
        check_vec("burst_occ", {1'b0, buffer_occupancy}, 8'd2);
        #2 n_rst = 1'b0;
        #1 check_vec("arst_occ", {1'b0, buffer_occupancy}, 8'd0);
        check_vec("arst_head", rx_data, 8'h00);
        #10 n_rst = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
